// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b, one full-subtractor step per clock, LSB first.
// Optional macro SERIAL_SUB_SAT_EN clamps the result to 0 when the final borrow is set.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             zero
);

   localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_sh_q, a_sh_d;
   logic [WIDTH-1:0]   b_sh_q, b_sh_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               bin_q, bin_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic               borrow_q, borrow_d;
   logic               zero_q, zero_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               a_bit, b_bit, d_bit, bout;
   logic [WIDTH-1:0]   res_next, diff_fin;

   // Next-state, datapath step and result capture
   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_d    = res_q;
      idx_d    = idx_q;
      bin_d    = bin_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      zero_d   = zero_q;

      a_bit    = a_sh_q[0];
      b_bit    = b_sh_q[0];
      d_bit    = a_bit ^ b_bit ^ bin_q;
      bout     = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin_q);
      res_next = {d_bit, res_q[WIDTH-1:1]};
      diff_fin = res_next;
`ifdef SERIAL_SUB_SAT_EN
      if (bout) diff_fin = '0;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               a_sh_d  = a;
               b_sh_d  = b;
               res_d   = '0;
               idx_d   = '0;
               bin_d   = 1'b0;
            end
         end
         ST_RUN: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            res_d  = res_next;
            bin_d  = bout;
            idx_d  = IDX_W'(idx_q + 1'b1);
            // Last bit: publish result on the same edge that enters DONE
            if (idx_q == IDX_W'(WIDTH - 1)) begin
               state_d  = ST_DONE;
               diff_d   = diff_fin;
               borrow_d = bout;
               zero_d   = (diff_fin == '0);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_q    <= '0;
         idx_q    <= '0;
         bin_q    <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         zero_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_q    <= res_d;
         idx_q    <= idx_d;
         bin_q    <= bin_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         zero_q   <= zero_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign diff   = diff_q;
   assign borrow = borrow_q;
   assign zero   = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8; define SERIAL_SUB_SAT_EN to check the saturating build.
module tb_serial_subtractor;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic       done;
   logic [7:0] diff;
   logic       borrow;
   logic       zero;

   int n_cmp = 0;
   int n_err = 0;
   int dones;

   serial_subtractor #(.WIDTH(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow),
      .zero   (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Launch one op, check busy for 8 cycles, then done pulse and result.
   task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] ed, input logic eb, input logic ez);
      @(negedge clk);
      a = av; b = bv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
         chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
         @(negedge clk);
      end
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_idlebusy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_diff"}, {24'd0, diff}, {24'd0, ed});
      chk({tag, "_borrow"}, {31'd0, borrow}, {31'd0, eb});
      chk({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
      @(negedge clk);
      chk({tag, "_donelow"}, {31'd0, done}, 32'd0);
      chk({tag, "_hold"}, {24'd0, diff}, {24'd0, ed});
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
      #12;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_diff", {24'd0, diff}, 32'd0);
      chk("rst_borrow", {31'd0, borrow}, 32'd0);
      chk("rst_zero", {31'd0, zero}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("basic", 8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);
`ifdef SERIAL_SUB_SAT_EN
      run_op("under", 8'h10, 8'h20, 8'h00, 1'b1, 1'b1);
`else
      run_op("under", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
`endif
      run_op("equal", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1);
      run_op("mid", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0);

      // Start re-asserted mid-run with new operands must be ignored
      @(negedge clk);
      a = 8'h33; b = 8'h11; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dones = 0;
      for (int i = 1; i <= 12; i++) begin
         if (i == 3) begin a = 8'h01; b = 8'h02; start = 1'b1; end
         if (i == 4) start = 1'b0;
         if (done) begin
            dones++;
            chk("ign_diff", {24'd0, diff}, 32'h22);
            chk("ign_borrow", {31'd0, borrow}, 32'd0);
         end
         @(negedge clk);
      end
      chk("ign_onedone", dones, 32'd1);
      chk("ign_idle", {31'd0, busy}, 32'd0);

      // Reset at cycle 4 of RUN aborts with all outputs cleared at once
      @(negedge clk);
      a = 8'h5A; b = 8'h3C; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_prebusy", {31'd0, busy}, 32'd1);
      chk("abort_prediff", {24'd0, diff}, 32'h22);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_diff", {24'd0, diff}, 32'd0);
      chk("abort_borrow", {31'd0, borrow}, 32'd0);
      chk("abort_zero", {31'd0, zero}, 32'd0);
      dones = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      chk("abort_nodone", dones, 32'd0);
      run_op("fresh", 8'hC8, 8'h64, 8'h64, 1'b0, 1'b0);

      // Start held high: each DONE is followed by exactly one IDLE cycle
      @(negedge clk);
      a = 8'h01; b = 8'h02; start = 1'b1;
      for (int op = 0; op < 2; op++) begin
         @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            chk("b2b_busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
         end
         chk("b2b_done", {31'd0, done}, 32'd1);
`ifdef SERIAL_SUB_SAT_EN
         chk("b2b_diff", {24'd0, diff}, 32'h00);
         chk("b2b_zero", {31'd0, zero}, 32'd1);
`else
         chk("b2b_diff", {24'd0, diff}, 32'hFF);
         chk("b2b_zero", {31'd0, zero}, 32'd0);
`endif
         chk("b2b_borrow", {31'd0, borrow}, 32'd1);
         @(negedge clk);
         chk("b2b_gap_busy", {31'd0, busy}, 32'd0);
         chk("b2b_gap_done", {31'd0, done}, 32'd0);
      end
      @(negedge clk);
      chk("b2b_rerun", {31'd0, busy}, 32'd1);
      start = 1'b0;
      repeat (12) @(negedge clk);
      chk("final_idle", {31'd0, busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; legal values are 2 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: the minuend.
REQ-006 The block SHALL have port b, input, WIDTH bits: the subtrahend.
REQ-007 The block SHALL have port busy, output, 1 bit: high while the operation is in RUN.
REQ-008 The block SHALL have port done, output, 1 bit: a one-cycle pulse meaning the result is valid.
REQ-009 The block SHALL have port diff, output, WIDTH bits: the registered difference.
REQ-010 The block SHALL have port borrow, output, 1 bit: the registered final borrow-out, high when a < b unsigned.
REQ-011 The block SHALL have port zero, output, 1 bit: the registered flag, high when diff equals 0.

Function
REQ-012 The FSM SHALL have the states IDLE, RUN and DONE.
  - IDLE->RUN on start=1.
  - RUN->DONE after WIDTH RUN cycles.
  - DONE->IDLE unconditionally.
REQ-013 On the edge that accepts start, the block SHALL capture a and b into internal shift registers, clear the bit index and clear the borrow-in.
  - a and b are not sampled again until the next accept.
REQ-014 Each RUN cycle SHALL process bit i, LSB first, as a full-subtractor step and shift d_i into the result register:
  - d_i = a_i ^ b_i ^ bin
  - bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin)
REQ-015 Latency: if start is accepted at edge k, done SHALL be high during the cycle after edge k+WIDTH and low in all other cycles.
REQ-016 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-017 diff, borrow and zero SHALL update only on the RUN->DONE edge, and SHALL hold until the next completed operation.
REQ-018 start SHALL be ignored while in RUN or DONE, with no queuing; a start held high in DONE SHALL be accepted on the following IDLE cycle.
REQ-019 borrow SHALL equal the final bout; diff SHALL equal (a - b) mod 2^WIDTH, except as modified by REQ-024.
REQ-020 zero SHALL be evaluated on the final value driven on diff, after any saturation.

Reset
REQ-021 When rst_n=0, the block SHALL immediately force state=IDLE, busy=0, done=0, diff=0, borrow=0 and zero=0, and clear all internal registers, regardless of clk.
REQ-022 A reset during RUN or DONE SHALL abort the operation, and no done pulse SHALL follow.
REQ-023 The first start after reset release SHALL be accepted on the first rising edge at which rst_n=1 and start=1.

Configuration
REQ-024 With macro SERIAL_SUB_SAT_EN defined, the block SHALL saturate: when the final borrow is 1, diff is forced to 0 (so zero=1), and borrow still reports 1.
  - Without the macro, diff SHALL be the modular result of REQ-019 and no saturation logic SHALL be present.

Verification
REQ-025 The bench SHALL cover the following scenarios, all at WIDTH=8:
  - a=0x5A, b=0x3C, start pulse -> busy for 8 cycles, then done pulse; diff=0x1E, borrow=0, zero=0.
  - a=0x10, b=0x20 -> borrow=1; diff=0xF0 without SERIAL_SUB_SAT_EN, diff=0x00 and zero=1 with it.
  - a=0xFF, b=0xFF -> diff=0x00, borrow=0, zero=1, done exactly 8 edges after accept.
  - start re-asserted with new operands at cycle 3 of RUN -> ignored; the result matches the original operands; exactly one done pulse.
  - rst_n pulled low at cycle 4 of RUN -> all outputs 0 at once, no done pulse; a fresh start after release gives the correct result.
  - start held high continuously with a=0x01, b=0x02 -> back-to-back operations with one IDLE cycle between each done and the next busy; each result diff=0xFF, borrow=1 (modular build).
